mem_stage_ctrl: RTL and testbench

//  MEM-stage data-memory access controller between the EX/MEM and MEM/WB pipeline registers.

---
 rtl/mem_stage_pkg.sv | 50 +++++
 rtl/mem_load_align.sv | 39 +++
 rtl/mem_stage_ctrl.sv | 139 +++++++++++++
 tb/tb_mem_stage_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// MEM-stage shared definitions: access size codes, controller states
// and small address-decode helpers.
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Size code 11 behaves as a word everywhere.
    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            default: return lo != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] store_be(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        case (size)
            SZ_BYTE: return 4'b0001 << lo;
            SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(
        input logic [1:0]  size,
        input logic [31:0] wd
    );
        case (size)
            SZ_BYTE: return {4{wd[7:0]}};
            SZ_HALF: return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load formatter: picks the byte/half lane from a raw read word
// and sign- or zero-extends it to 32 bits.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_lo,
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_lo)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
        endcase
    end

    assign w_half = i_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = i_rdata;
        case (i_size)
            SZ_BYTE: o_data = i_uns ? {24'd0, w_byte}
                                    : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: o_data = i_uns ? {16'd0, w_half}
                                    : {{16{w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory controller: req/ack sequencing, store/load
// formatting, pipeline stall, misalignment and bus-timeout reporting.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_read_in,
    input  logic          mem_write_in,
    input  logic [1:0]    mem_size_in,
    input  logic          mem_unsigned_in,
    input  logic [AW-1:0] addr_in,
    input  logic [DW-1:0] wdata_in,
    output logic          dm_req,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [3:0]    dm_be,
    output logic [DW-1:0] dm_wdata,
    input  logic          dm_ack,
    input  logic [DW-1:0] dm_rdata,
    output logic [DW-1:0] load_data,
    output logic          mem_stall,
    output logic          misalign,
    output logic          bus_err
);

    state_t          r_state;
    logic [TO_W-1:0] r_cnt;
    logic            r_req;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [3:0]      r_be;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_load;
    logic            r_bus_err;
    logic [1:0]      r_size;
    logic [1:0]      r_lo;
    logic            r_uns;

    logic            w_access;
    logic            w_mis;
    logic            w_wr;
    logic            w_start;
    logic            w_idle;
    logic            w_last;
    logic [3:0]      w_be;
    logic [DW-1:0]   w_wdata;
    logic [DW-1:0]   w_load;

    assign w_access = mem_read_in | mem_write_in;
    assign w_mis    = is_misaligned(mem_size_in, addr_in[1:0]);
    // A simultaneous read/write request is serviced as a read.
    assign w_wr     = mem_write_in & ~mem_read_in;
    assign w_idle   = r_state == ST_IDLE;
    assign w_start  = w_idle & w_access & ~w_mis;
    assign w_last   = r_cnt == TO_W'(TIMEOUT - 1);
    assign w_be     = w_wr ? store_be(mem_size_in, addr_in[1:0]) : 4'b1111;
    assign w_wdata  = w_wr ? store_data(mem_size_in, wdata_in) : '0;

    mem_load_align u_align (
        .i_rdata (dm_rdata),
        .i_lo    (r_lo),
        .i_size  (r_size),
        .i_uns   (r_uns),
        .o_data  (w_load)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_load    <= '0;
            r_bus_err <= 1'b0;
            r_size    <= SZ_BYTE;
            r_lo      <= 2'b00;
            r_uns     <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                        r_we    <= w_wr;
                        r_addr  <= {addr_in[AW-1:2], 2'b00};
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_cnt   <= '0;
                        r_size  <= mem_size_in;
                        r_lo    <= addr_in[1:0];
                        r_uns   <= mem_unsigned_in;
                    end
                end
                ST_REQ: begin
                    if (dm_ack) begin
                        r_state <= ST_DONE;
                        r_req   <= 1'b0;
                        if (!r_we) begin
                            r_load <= w_load;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state   <= ST_ERR;
                            r_req     <= 1'b0;
                            r_bus_err <= 1'b1;
                            r_load    <= '0;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                ST_ERR:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign dm_req    = r_req;
    assign dm_we     = r_we;
    assign dm_addr   = r_addr;
    assign dm_be     = r_be;
    assign dm_wdata  = r_wdata;
    assign load_data = r_load;
    assign bus_err   = r_bus_err;

    // Stall covers the issuing IDLE cycle so the instruction stays put.
    assign mem_stall = ~rst & (w_start | (r_state == ST_REQ));
    assign misalign  = ~rst & w_idle & w_access & w_mis;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: load/store formatting, latency,
// misalignment, timeout and reset-abort sequences.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read_in = 1'b0;
    logic        mem_write_in = 1'b0;
    logic [1:0]  mem_size_in = 2'b00;
    logic        mem_unsigned_in = 1'b0;
    logic [31:0] addr_in = '0;
    logic [31:0] wdata_in = '0;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack = 1'b0;
    logic [31:0] dm_rdata = '0;
    logic [31:0] load_data;
    logic        mem_stall;
    logic        misalign;
    logic        bus_err;

    int n_vec = 0;
    int n_err = 0;
    int n_rise;
    logic prev_req;

    always #5 clk = ~clk;

    mem_stage_ctrl #(
        .AW(32), .DW(32), .TIMEOUT(4), .TO_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_size_in(mem_size_in), .mem_unsigned_in(mem_unsigned_in),
        .addr_in(addr_in), .wdata_in(wdata_in),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_be(dm_be), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .load_data(load_data), .mem_stall(mem_stall),
        .misalign(misalign), .bus_err(bus_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_req <= 1'b0;
            n_rise   <= 0;
        end else begin
            prev_req <= dm_req;
            if (dm_req && !prev_req) n_rise <= n_rise + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setup(input logic rd, input logic wr,
                         input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        mem_read_in     = rd;
        mem_write_in    = wr;
        mem_size_in     = sz;
        mem_unsigned_in = uns;
        addr_in         = a;
        wdata_in        = wd;
    endtask

    task automatic idle();
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        dm_ack       = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Runs one access from its IDLE cycle until stall drops; ack_at=0
    // means never acknowledge.
    task automatic access(input int ack_at, output int st, output int rq,
                          output logic [31:0] s_addr,
                          output logic [3:0] s_be, output logic s_we,
                          output logic [31:0] s_wd);
        st = 0; rq = 0;
        s_addr = '0; s_be = '0; s_we = 1'b0; s_wd = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_stall) st++;
            if (dm_req) begin
                rq++;
                if (rq == 1) begin
                    s_addr = dm_addr; s_be = dm_be;
                    s_we = dm_we; s_wd = dm_wdata;
                end
            end
            dm_ack = dm_req && (rq == ack_at);
            if (!mem_stall) break;
        end
    endtask

    initial begin
        int st, rq, base;
        logic [31:0] sa, sw;
        logic [3:0] sb;
        logic swe;

        // Reset with a misaligned load pending: all outputs quiet.
        setup(1, 0, 2'b10, 0, 32'h1001, 0);
        #3;
        chk("rst_stall", mem_stall, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_req", dm_req, 0);
        chk("rst_load", load_data, 0);
        chk("rst_buserr", bus_err, 0);
        chk("rst_addr", dm_addr, 0);
        chk("rst_be", dm_be, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // lb signed, ack on 3rd REQ cycle
        dm_rdata = 32'h80AABBCC;
        setup(1, 0, 2'b00, 0, 32'h1003, 0);
        access(3, st, rq, sa, sb, swe, sw);
        chk("lb_stall", st, 4);
        chk("lb_reqcyc", rq, 3);
        chk("lb_addr", sa, 32'h1000);
        chk("lb_be", sb, 4'hF);
        chk("lb_we", swe, 0);
        chk("lb_data", load_data, 32'hFFFFFF80);
        chk("lb_done_req", dm_req, 0);
        idle();

        setup(1, 0, 2'b00, 1, 32'h1002, 0);
        access(1, st, rq, sa, sb, swe, sw);
        chk("lbu_stall", st, 2);
        chk("lbu_data", load_data, 32'h000000AA);
        idle();

        setup(1, 0, 2'b01, 1, 32'h1002, 0);
        access(1, st, rq, sa, sb, swe, sw);
        chk("lhu_data", load_data, 32'h000080AA);
        idle();

        setup(1, 0, 2'b01, 0, 32'h1002, 0);
        access(1, st, rq, sa, sb, swe, sw);
        chk("lh_data", load_data, 32'hFFFF80AA);
        idle();

        setup(1, 0, 2'b00, 0, 32'h1000, 0);
        access(1, st, rq, sa, sb, swe, sw);
        chk("lb0_data", load_data, 32'hFFFFFFCC);
        idle();

        // Read and write both asserted: read wins.
        setup(1, 1, 2'b10, 0, 32'h1000, 32'h55555555);
        access(1, st, rq, sa, sb, swe, sw);
        chk("rw_we", swe, 0);
        chk("rw_be", sb, 4'hF);
        chk("rw_data", load_data, 32'h80AABBCC);
        idle();

        // sh with immediate ack
        setup(0, 1, 2'b01, 0, 32'h2002, 32'h00001234);
        access(1, st, rq, sa, sb, swe, sw);
        chk("sh_stall", st, 2);
        chk("sh_reqcyc", rq, 1);
        chk("sh_we", swe, 1);
        chk("sh_be", sb, 4'b1100);
        chk("sh_wdata", sw, 32'h12341234);
        chk("sh_addr", sa, 32'h2000);
        chk("sh_keep_load", load_data, 32'h80AABBCC);
        idle();

        setup(0, 1, 2'b00, 0, 32'h2001, 32'h000000AB);
        access(1, st, rq, sa, sb, swe, sw);
        chk("sb_be", sb, 4'b0010);
        chk("sb_wdata", sw, 32'hABABABAB);
        idle();

        // Misaligned lw and sh: flagged, no request, no stall.
        setup(1, 0, 2'b10, 0, 32'h2001, 0);
        @(negedge clk);
        chk("lw_mis_flag", misalign, 1);
        chk("lw_mis_stall", mem_stall, 0);
        @(negedge clk);
        chk("lw_mis_req", dm_req, 0);
        idle();

        setup(0, 1, 2'b01, 0, 32'h2003, 32'hFFFF);
        @(negedge clk);
        chk("sh_mis_flag", misalign, 1);
        @(negedge clk);
        chk("sh_mis_req", dm_req, 0);
        idle();

        // Timeout after 4 unacked REQ cycles.
        setup(1, 0, 2'b10, 0, 32'h1000, 0);
        access(0, st, rq, sa, sb, swe, sw);
        chk("to_stall", st, 5);
        chk("to_reqcyc", rq, 4);
        chk("to_buserr", bus_err, 1);
        chk("to_load", load_data, 0);
        idle();
        dm_ack = 1'b1;
        @(negedge clk);
        chk("to_pulse", bus_err, 0);
        chk("late_ack_stall", mem_stall, 0);
        @(posedge clk);
        #1;
        dm_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_req", dm_req, 0);
        chk("late_ack_load", load_data, 0);
        setup(1, 0, 2'b10, 0, 32'h1000, 0);
        access(1, st, rq, sa, sb, swe, sw);
        chk("post_to_data", load_data, 32'h80AABBCC);
        idle();

        // Reset mid-REQ aborts the access asynchronously.
        setup(1, 0, 2'b10, 0, 32'h1000, 0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_req", dm_req, 0);
        chk("abort_stall", mem_stall, 0);
        mem_read_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_idle_stall", mem_stall, 0);
        chk("abort_idle_req", dm_req, 0);
        @(posedge clk);
        #1;

        // Back-to-back sw then lw.
        base = n_rise;
        setup(0, 1, 2'b10, 0, 32'h3000, 32'hDEADBEEF);
        access(1, st, rq, sa, sb, swe, sw);
        chk("sw_be", sb, 4'hF);
        chk("sw_wdata", sw, 32'hDEADBEEF);
        dm_rdata = 32'h11223344;
        setup(1, 0, 2'b10, 0, 32'h3004, 0);
        dm_ack = 1'b0;
        @(posedge clk);
        #1;
        access(1, st, rq, sa, sb, swe, sw);
        chk("lw_addr", sa, 32'h3004);
        chk("lw_data", load_data, 32'h11223344);
        chk("lw_reqcyc", rq, 1);
        idle();
        @(negedge clk);
        chk("b2b_requests", n_rise - base, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
